// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Latency: n/a (constants, types and small helpers only).
// Backpressure: n/a.
// Contents: MD_* op codes, FSM state encoding, default width and latency.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_WIDTH   = 32;
    // PREP + WIDTH RUN cycles + FIX + DONE, counted in cycles from the start cycle
    localparam int MD_LATENCY = MD_WIDTH + 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is the only back-pressure; start is dropped while busy.
// master: issue side (start/op/operands/flush in, status and HI/LO out).
// slave:  the sequencer itself.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, stall, done, dz, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, stall, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shift-add multiplier or restoring divider (combinational).
// Latency: 0 cycles.
// Backpressure: none; the sequencer decides when the result is registered.
// Ports: div_i mode, acc_i/acc_o 2*WIDTH accumulator, mag_a_i/mag_b_i operand
//        magnitudes, bit_i next operand bit (MSB first) from the sequencer.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH:0]     mag_a_i,
    input  logic [WIDTH:0]     mag_b_i,
    input  logic               bit_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     rem_n;
    logic               ge;
    logic               unused_rem_msb;

    always_comb begin
        // Multiply, MSB-first Horner form: acc = 2*acc + bit*multiplicand
        mul_sum = {acc_i[2*WIDTH-2:0], 1'b0}
                + {{(WIDTH-1){1'b0}}, (bit_i ? mag_a_i : {(WIDTH+1){1'b0}})};

        // Divide: upper half is the partial remainder, lower half collects quotient bits
        trial = {acc_i[2*WIDTH-1:WIDTH], bit_i};
        ge    = (trial >= mag_b_i);
        diff  = trial - mag_b_i;
        rem_n = ge ? diff : trial;

        acc_o = div_i ? {rem_n[WIDTH-1:0], acc_i[WIDTH-2:0], ge} : mul_sum;
    end

    // The remainder is always below the divisor, so its top bit is never needed
    assign unused_rem_msb = rem_n[WIDTH];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Latency: done pulses MD_LATENCY (WIDTH+3) cycles after the start cycle.
// Backpressure: stall held while busy; start ignored unless IDLE; flush aborts.
// Ports: clk, reset (async, active-high); md (slave): start/op/rs_val/rt_val/flush
//        in, busy/stall/done/dz/hi/lo out.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave md
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e          state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   rs_q, rt_q;
    logic [WIDTH:0]     mag_a_q, mag_b_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic               res_neg_q, rem_neg_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dz_q;

    logic               busy_c, done_c, start_ok;
    logic               sign_a, sign_b;
    logic [WIDTH:0]     mag_a_d, mag_b_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, hi_d, lo_d;
    logic               dz_d;

    assign start_ok = md.start & ~md.flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_PREP;
            ST_PREP: state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && md.flush) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state_q)
            ST_PREP, ST_RUN, ST_FIX: busy_c = 1'b1;
            ST_DONE:                 done_c = 1'b1;
            default: ;
        endcase
    end

    assign md.busy  = busy_c;
    assign md.done  = done_c;
    assign md.stall = busy_c | (md.start & (state_q == ST_IDLE) & ~md.flush);
    assign md.dz    = dz_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

    // ---------------- operand conditioning ----------------
    // W+1-bit magnitudes keep |-2^(W-1)| representable, which is what makes the
    // most-negative / -1 divide come out right without a special case.
    always_comb begin
        sign_a  = md_is_signed(op_q) & rs_q[WIDTH-1];
        sign_b  = md_is_signed(op_q) & rt_q[WIDTH-1];
        mag_a_d = sign_a ? {1'b0, -rs_q} : {1'b0, rs_q};
        mag_b_d = sign_b ? {1'b0, -rt_q} : {1'b0, rt_q};
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i   (md_is_div(op_q)),
        .acc_i   (acc_q),
        .mag_a_i (mag_a_q),
        .mag_b_i (mag_b_q),
        .bit_i   (shreg_q[WIDTH-1]),
        .acc_o   (acc_step)
    );

    // ---------------- sign fix-up and result select ----------------
    always_comb begin
        prod_fix = res_neg_q ? -acc_q : acc_q;
        quot_fix = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        dz_d     = md_is_div(op_q) & (rt_q == '0);
        if (dz_d) begin
            // Datapath output is meaningless here; report dividend and all-ones
            hi_d = rs_q;
            lo_d = '1;
        end else if (md_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            shreg_q   <= '0;
            acc_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        op_q <= md.op;
                        rs_q <= md.rs_val;
                        rt_q <= md.rt_val;
                    end
                end
                ST_PREP: begin
                    mag_a_q   <= mag_a_d;
                    mag_b_q   <= mag_b_d;
                    res_neg_q <= sign_a ^ sign_b;
                    rem_neg_q <= sign_a;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    // Bits consumed MSB first: dividend for divide, multiplier for multiply
                    shreg_q   <= md_is_div(op_q) ? mag_a_d[WIDTH-1:0] : mag_b_d[WIDTH-1:0];
                end
                ST_RUN: begin
                    acc_q   <= acc_step;
                    shreg_q <= shreg_q << 1;
                    cnt_q   <= cnt_q + CW'(1);
                end
                ST_FIX: begin
                    // Commit happens on the edge into DONE; a flush here leaves HI/LO alone
                    if (!md.flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        dz_q <= dz_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int W   = 32;
    localparam int LAT = 35;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) md_if ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    // Model state: m_age = cycles since the start-sampling edge (0 = idle)
    int          m_age = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result from plain integer arithmetic
    function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sb, q, r;
        logic [63:0] p;
        z = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    z = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
        end else if (m_age == 0) begin
            if (md_if.start && !md_if.flush) begin
                ref_calc(md_if.op, md_if.rs_val, md_if.rt_val, p_hi, p_lo, p_dz);
                m_age = 1;
            end
        end else if (md_if.flush || m_age == LAT) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == LAT) begin
                m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            chk("busy", md_if.busy, (m_age >= 1 && m_age < LAT));
            chk("done", md_if.done, (m_age == LAT));
            chk("stall", md_if.stall,
                (m_age >= 1 && m_age < LAT) || (md_if.start && m_age == 0 && !md_if.flush));
            chk("hi", md_if.hi, m_hi);
            chk("lo", md_if.lo, m_lo);
            if (m_age == LAT) chk("dz", md_if.dz, m_dz);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic ez);
        logic [31:0] rh, rl;
        logic        rz;
        int          cyc;
        ref_calc(op, a, b, rh, rl, rz);
        chk({nm, " model_hi"}, rh, eh);
        chk({nm, " model_lo"}, rl, el);
        chk({nm, " model_dz"}, rz, ez);
        md_if.op = op; md_if.rs_val = a; md_if.rt_val = b; md_if.start = 1'b1;
        #1;
        chk({nm, " stall_c0"}, md_if.stall, 1);
        step();
        md_if.start = 1'b0;
        cyc = 1;
        while (!md_if.done && cyc < 60) begin
            chk({nm, " busy_run"}, md_if.busy, 1);
            step();
            cyc++;
        end
        chk({nm, " latency"}, cyc, LAT);
        chk({nm, " hi"}, md_if.hi, eh);
        chk({nm, " lo"}, md_if.lo, el);
        chk({nm, " dz"}, md_if.dz, ez);
        chk({nm, " busy_done"}, md_if.busy, 0);
        step();
        chk({nm, " done_pulse"}, md_if.done, 0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  cyc, guard;
        logic saw;
        md_if.start = 1'b0; md_if.flush = 1'b0; md_if.op = 2'b00;
        md_if.rs_val = '0; md_if.rt_val = '0;
        step(); step();
        chk("rst busy", md_if.busy, 0);
        chk("rst done", md_if.done, 0);
        chk("rst hi", md_if.hi, 0);
        chk("rst lo", md_if.lo, 0);
        chk("rst dz", md_if.dz, 0);
        reset = 1'b0;
        cmp_en = 1'b1;
        step();

        directed("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        directed("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        directed("DIVU 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        directed("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        directed("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        directed("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        directed("DIV -8/0", 2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        directed("DIVU 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        directed("MULTU 2*3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        // Flush mid-RUN with an ignored start while busy
        md_if.op = 2'b01; md_if.rs_val = 32'd3; md_if.rt_val = 32'd4; md_if.start = 1'b1;
        cyc = 0; saw = 1'b0;
        while (cyc < 11) begin
            step();
            cyc++;
            if (md_if.done) saw = 1'b1;
            md_if.start = (cyc == 5);
            if (cyc == 5) begin
                md_if.op = 2'b11; md_if.rs_val = 32'd9; md_if.rt_val = 32'd3;
            end
            md_if.flush = (cyc == 10);
        end
        chk("flush no_done", saw, 0);
        chk("flush busy_c11", md_if.busy, 0);
        chk("flush hi_kept", md_if.hi, 32'd0);
        chk("flush lo_kept", md_if.lo, 32'd6);
        step();
        cyc = 12;
        md_if.op = 2'b01; md_if.rs_val = 32'd3; md_if.rt_val = 32'd4; md_if.start = 1'b1;
        step();
        md_if.start = 1'b0;
        cyc = 13;
        while (!md_if.done && cyc < 80) begin
            step();
            cyc++;
        end
        chk("flush restart_cycle", cyc, 47);
        chk("flush restart_lo", md_if.lo, 32'd12);
        chk("flush restart_hi", md_if.hi, 32'd0);
        step();

        // Asynchronous reset in the middle of RUN
        md_if.op = 2'b01; md_if.rs_val = 32'h1234; md_if.rt_val = 32'h5678; md_if.start = 1'b1;
        step();
        md_if.start = 1'b0;
        repeat (19) step();
        #1 reset = 1'b1;
        #1;
        chk("areset busy", md_if.busy, 0);
        chk("areset done", md_if.done, 0);
        chk("areset hi", md_if.hi, 0);
        chk("areset lo", md_if.lo, 0);
        chk("areset stall", md_if.stall, 0);
        step();
        reset = 1'b0;
        step();
        directed("post-reset MULTU", 2'b01, 32'h1234, 32'h5678, 32'h0, 32'h0626_0060, 1'b0);

        // Randomized traffic with stray starts and occasional flushes
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) step();
            md_if.op = 2'($urandom_range(0, 3));
            md_if.rs_val = rnd_operand();
            md_if.rt_val = rnd_operand();
            md_if.start = 1'b1;
            md_if.flush = ($urandom_range(0, 9) == 0);
            step();
            guard = 0;
            while (m_age != 0 && guard < 60) begin
                md_if.start = ($urandom_range(0, 7) == 0);
                md_if.op = 2'($urandom_range(0, 3));
                md_if.rs_val = $urandom;
                md_if.rt_val = $urandom;
                md_if.flush = ($urandom_range(0, 59) == 0);
                step();
                guard++;
            end
            md_if.start = 1'b0;
            md_if.flush = 1'b0;
            chk("random timeout", (guard < 60), 1);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
